// File: rtl/logic_unit_pkg.sv
// Shared opcodes and stage payload layout for the pipelined logic unit.
package logic_unit_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  // Condition flags travel in the two LSBs of the payload: {result, zf, sf}.
  typedef struct packed {
    logic zf;
    logic sf;
  } flags_t;

  localparam int FLAG_BITS = $bits(flags_t);

  function automatic int payload_width(input int width);
    return width + FLAG_BITS;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/ready register slice. Ready looks only at the local valid and the
// downstream ready, so an empty slice never blocks the slice behind it.
module logic_pipe_stage #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [PW-1:0] data_q, data_d;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Load a new beat (or a bubble) whenever this slice is free or draining.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  // Slice registers; reset discards any beat held here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pipelined_logic_unit.sv
// Pipelined AND/OR/XOR/XNOR unit with zero/sign flags and valid/ready on both
// sides. Stage 0 computes; the remaining stages only carry the payload.
module pipelined_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic [2:0]       occupancy
);

  localparam int PW = payload_width(WIDTH);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $fatal(1, "pipelined_logic_unit: STAGES=%0d outside 1..4", STAGES);
  end

  logic [WIDTH-1:0] res_c;
  flags_t           flags_c;

  logic          stage_valid [0:STAGES];
  logic          stage_ready [0:STAGES];
  logic [PW-1:0] stage_data  [0:STAGES];

  logic       push, pop;
  logic [2:0] occ_q, occ_d;

  // Stage-0 compute: opcode select plus flags from the full-width result.
  always_comb begin
    case (op)
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      default: res_c = ~(a ^ b);
    endcase
    flags_c.zf = ~|res_c;
    flags_c.sf = res_c[WIDTH-1];
  end

  assign stage_valid[0]      = in_valid;
  assign stage_data[0]       = {res_c, flags_c};
  assign stage_ready[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic_pipe_stage #(.PW(PW)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (stage_valid[i]),
      .in_ready  (stage_ready[i]),
      .in_data   (stage_data[i]),
      .out_valid (stage_valid[i+1]),
      .out_ready (stage_ready[i+1]),
      .out_data  (stage_data[i+1])
    );
  end

  assign in_ready                = stage_ready[0];
  assign out_valid               = stage_valid[STAGES];
  assign {result, zf, sf}        = stage_data[STAGES];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Occupancy tracks beats in flight; a same-cycle push and pop cancel.
  always_comb begin
    occ_d = occ_q;
    if (push & ~pop)      occ_d = occ_q + 3'd1;
    else if (pop & ~push) occ_d = occ_q - 3'd1;
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= 3'd0;
    else     occ_q <= occ_d;
  end

  assign occupancy = occ_q;

endmodule
